// File: rtl/addsub_scheduler_pkg.sv
// Shared types and constants for the two-requester add/sub burst scheduler.
// The datapath latency is fixed by the external adder/subtractor and sizes the tag pipeline.
package addsub_scheduler_pkg;

  localparam int LAT = 2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_Z = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic id;
  } tag_t;

endpackage

// File: rtl/addsub_scheduler_arb.sv
// Two-way round-robin arbiter: the pointer holder wins ties, and the pointer moves
// to the other requester when the current owner finishes its burst.
module addsub_rr_arb
  import addsub_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       done_id,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ptr_d = advance ? ~done_id : ptr_q;
    gnt   = 2'b00;
    if (req[ptr_q]) begin
      gnt[ptr_q] = 1'b1;
    end else if (req[~ptr_q]) begin
      gnt[~ptr_q] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/addsub_scheduler.sv
// Burst scheduler sharing one registered add/sub datapath between two requesters;
// a tag pipeline matching the datapath latency collects one final sum per burst.
module addsub_scheduler
  import addsub_scheduler_pkg::*;
#(
  parameter int N  = 16,
  parameter int LW = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [1:0]    req,
  input  logic [N-1:0]  a0,
  input  logic [N-1:0]  a1,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  input  logic [N-1:0]  b0,
  input  logic [N-1:0]  b1,
  input  logic [1:0]    sub,
  input  logic [1:0]    bvalid,
  output logic [1:0]    grant,
  output logic [1:0]    take,
  output logic [N-1:0]  dp_a,
  output logic [N-1:0]  dp_b,
  output logic          dp_sel,
  output logic          dp_addsub,
  input  logic [N-1:0]  dp_z,
  input  logic          dp_ovf,
  output logic          res_valid,
  output logic          res_id,
  output logic [N-1:0]  res_z,
  output logic          res_ovf,
  output logic          busy
);

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            first_q, first_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [N-1:0]    a_q, a_d;
  tag_t [LAT-1:0]  pipe_q, pipe_d;
  logic            ovf_acc_q, ovf_acc_d;
  logic            res_valid_q, res_valid_d;
  logic            res_id_q, res_id_d;
  logic [N-1:0]    res_z_q, res_z_d;
  logic            res_ovf_q, res_ovf_d;

  logic [1:0]      arb_gnt;
  logic [LW-1:0]   len_sel;
  logic            issue, last_beat, advance, ovf_now;
  tag_t            new_tag, tail;

  addsub_rr_arb u_arb (
    .clk     (Clock),
    .rst_n   (Resetn),
    .req     (req),
    .advance (advance),
    .done_id (owner_q),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    first_d   = first_q;
    rem_d     = rem_q;
    a_d       = a_q;
    take      = 2'b00;
    dp_a      = '0;
    dp_b      = '0;
    dp_sel    = SEL_A;
    dp_addsub = 1'b0;
    issue     = 1'b0;
    advance   = 1'b0;
    last_beat = (rem_q == LW'(1));
    len_sel   = arb_gnt[1] ? len1 : len0;

    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          state_d = RUN;
          owner_d = arb_gnt[1];
          first_d = 1'b1;
          a_d     = arb_gnt[1] ? a1 : a0;
          rem_d   = (len_sel == '0) ? LW'(1) : len_sel;
        end
      end
      RUN: begin
        if (bvalid[owner_q]) begin
          issue          = 1'b1;
          take[owner_q]  = 1'b1;
          dp_b           = owner_q ? b1 : b0;
          dp_addsub      = sub[owner_q];
          rem_d          = rem_q - LW'(1);
          if (first_q) begin
            dp_a    = a_q;
            first_d = 1'b0;
          end else begin
            dp_sel = SEL_Z;
          end
          if (last_beat) begin
            state_d = IDLE;
            advance = 1'b1;
          end
        end else if (!first_q) begin
          // Hold beat: Z + 0 keeps the partial sum alive through a bubble.
          dp_sel = SEL_Z;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The tag pipeline tail lines up with dp_z/dp_ovf of the same beat.
  always_comb begin
    new_tag     = issue ? tag_t'{valid: 1'b1, first: first_q, last: last_beat, id: owner_q}
                        : tag_t'('0);
    pipe_d      = {pipe_q[LAT-2:0], new_tag};
    tail        = pipe_q[LAT-1];
    ovf_now     = tail.first ? dp_ovf : (ovf_acc_q | dp_ovf);
    ovf_acc_d   = ovf_acc_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_z_d     = res_z_q;
    res_ovf_d   = res_ovf_q;
    if (tail.valid) begin
      ovf_acc_d = ovf_now;
      if (tail.last) begin
        res_valid_d = 1'b1;
        res_id_d    = tail.id;
        res_z_d     = dp_z;
        res_ovf_d   = ovf_now;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      first_q     <= 1'b0;
      rem_q       <= '0;
      a_q         <= '0;
      pipe_q      <= '0;
      ovf_acc_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_z_q     <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      first_q     <= first_d;
      rem_q       <= rem_d;
      a_q         <= a_d;
      pipe_q      <= pipe_d;
      ovf_acc_q   <= ovf_acc_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_z_q     <= res_z_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (state_q == RUN) grant[owner_q] = 1'b1;
    busy = (state_q != IDLE);
    for (int i = 0; i < LAT; i++) busy = busy | pipe_q[i].valid;
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_z     = res_z_q;
  assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_addsub_scheduler.sv
// Directed bench for addsub_scheduler with a behavioural 2-cycle add/sub datapath
// (input registers, then Z/overflow register with Sel feedback) beside it.
module tb_addsub_scheduler;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [1:0]  req, sub, bvalid, grant, take;
  logic [15:0] a0, a1, b0, b1, dp_a, dp_b, dp_z, res_z;
  logic [7:0]  len0, len1;
  logic        dp_sel, dp_addsub, dp_ovf, res_valid, res_id, res_ovf, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int popped_cyc;

  typedef struct {
    bit          id;
    logic [15:0] z;
    bit          ovf;
    int          cyc;
  } res_t;
  res_t       rq[$];
  logic [1:0] gseen[$];

  addsub_scheduler #(.N(16), .LW(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .a0(a0), .a1(a1),
    .len0(len0), .len1(len1), .b0(b0), .b1(b1), .sub(sub), .bvalid(bvalid),
    .grant(grant), .take(take), .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel),
    .dp_addsub(dp_addsub), .dp_z(dp_z), .dp_ovf(dp_ovf), .res_valid(res_valid),
    .res_id(res_id), .res_z(res_z), .res_ovf(res_ovf), .busy(busy)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Datapath model, reset tied to ~Resetn.
  logic        dp_rst;
  logic [15:0] ra, rb, zq, opnd, sum;
  logic        rsel, rsub, ovfq, ovf_c;
  assign dp_rst = ~Resetn;
  always_comb begin
    opnd  = rsel ? zq : ra;
    sum   = rsub ? opnd - rb : opnd + rb;
    ovf_c = rsub ? ((opnd[15] != rb[15]) && (sum[15] != opnd[15]))
                 : ((opnd[15] == rb[15]) && (sum[15] != opnd[15]));
  end
  always_ff @(posedge Clock or posedge dp_rst) begin
    if (dp_rst) begin
      ra <= '0; rb <= '0; rsel <= 1'b0; rsub <= 1'b0; zq <= '0; ovfq <= 1'b0;
    end else begin
      ra <= dp_a; rb <= dp_b; rsel <= dp_sel; rsub <= dp_addsub; zq <= sum; ovfq <= ovf_c;
    end
  end
  assign dp_z   = zq;
  assign dp_ovf = ovfq;

  always @(negedge Clock)
    if (Resetn && res_valid) rq.push_back(res_t'{id: res_id, z: res_z, ovf: res_ovf, cyc: cyc});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_results(input string tag, input int n);
    int g = 0;
    while (rq.size() < n && g < 40) begin
      @(negedge Clock);
      g++;
    end
    check({tag, "_wait"}, rq.size() >= n, 1);
  endtask

  task automatic expect_res(input string tag, input bit id, input logic [15:0] z, input bit ovf);
    res_t r;
    check({tag, "_avail"}, rq.size() > 0, 1);
    if (rq.size() > 0) begin
      r = rq.pop_front();
      check({tag, "_id"}, r.id, id);
      check({tag, "_z"}, r.z, z);
      check({tag, "_ovf"}, r.ovf, ovf);
      popped_cyc = r.cyc;
    end
  endtask

  // One requester's burst; gap_at inserts two bubbles after that many beats.
  task automatic run_burst(input bit id, input logic [15:0] a, input logic [7:0] len,
                           input int nb, input logic [15:0] bs [4], input bit ss [4],
                           input int gap_at, output int last_take);
    int k = 0, bub = 0, guard = 0;
    bit granted = 0;
    last_take = 0;
    if (id) begin a1 = a; len1 = len; b1 = bs[0]; end
    else    begin a0 = a; len0 = len; b0 = bs[0]; end
    sub[id] = ss[0]; bvalid[id] = 1'b1; req[id] = 1'b1;
    while (k < nb && guard < 60) begin
      @(negedge Clock);
      guard++;
      if (grant[id]) granted = 1;
      if (take[id]) begin
        k++;
        last_take = cyc;
      end else if (granted && !bvalid[id] && k > 0) begin
        check("hold_sel", dp_sel, 1);
        check("hold_b", dp_b, 0);
      end
      @(posedge Clock); #1;
      if (granted) req[id] = 1'b0;
      if (k == gap_at && bub < 2) begin
        bvalid[id] = 1'b0;
        bub++;
      end else if (k < nb) begin
        bvalid[id] = 1'b1;
        if (id) b1 = bs[k]; else b0 = bs[k];
        sub[id] = ss[k];
      end else begin
        bvalid[id] = 1'b0;
      end
    end
    bvalid[id] = 1'b0; req[id] = 1'b0;
    check("burst_done", guard < 60, 1);
  endtask

  // Both requesters active; each drops req once granted; grant order lands in gseen.
  task automatic serve_both(input string tag, input int n);
    int guard = 0;
    logic [1:0] last_g = 2'b00;
    gseen.delete();
    while (rq.size() < n && guard < 40) begin
      @(negedge Clock);
      guard++;
      if (grant != 2'b00 && grant != last_g) gseen.push_back(grant);
      last_g = grant;
      @(posedge Clock); #1;
      if (last_g[0]) req[0] = 1'b0;
      if (last_g[1]) req[1] = 1'b0;
    end
    bvalid = 2'b00; req = 2'b00;
    check({tag, "_done"}, guard < 40, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lt, c1, g;
    Resetn = 1'b0; req = '0; sub = '0; bvalid = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; len0 = '0; len1 = '0;
    @(negedge Clock);
    check("rst_grant", grant, 0);
    check("rst_take", take, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_dp_a", dp_a, 0);
    check("rst_dp_sel", dp_sel, 0);
    @(posedge Clock); #1;
    Resetn = 1'b1;
    @(negedge Clock);
    check("idle_busy", busy, 0);

    // Single add burst: 10 + 5 + 7 - 2 = 20.
    @(posedge Clock); #1;
    run_burst(0, 16'd10, 8'd3, 3, '{16'd5, 16'd7, 16'hFFFE, 16'd0}, '{0, 0, 0, 0}, -1, lt);
    wait_results("add", 1);
    expect_res("add", 0, 16'd20, 0);
    check("add_lat", popped_cyc - lt, 3);

    // Subtract with sticky overflow: 0x7FF0 + 0x20 - 0x30.
    run_burst(1, 16'h7FF0, 8'd2, 2, '{16'h0020, 16'h0030, 16'd0, 16'd0}, '{0, 1, 0, 0}, -1, lt);
    wait_results("ovf", 1);
    expect_res("ovf", 1, 16'h7FE0, 1);
    check("ovf_lat", popped_cyc - lt, 3);

    // Bubbles between beats 1 and 2: 100 + 1 + 2 + 3.
    run_burst(0, 16'd100, 8'd3, 3, '{16'd1, 16'd2, 16'd3, 16'd0}, '{0, 0, 0, 0}, 1, lt);
    wait_results("bub", 1);
    expect_res("bub", 0, 16'd106, 0);

    // Contention from reset: requester 0 first, then 1.
    Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b1;
    rq.delete();
    a0 = 16'd100; len0 = 8'd2; b0 = 16'd1; a1 = 16'd200; len1 = 8'd2; b1 = 16'd3;
    sub = 2'b10; bvalid = 2'b11; req = 2'b11;
    serve_both("cont", 2);
    check("cont_ngrants", gseen.size(), 2);
    if (gseen.size() == 2) begin
      check("cont_first", gseen[0], 2'b01);
      check("cont_second", gseen[1], 2'b10);
    end
    expect_res("cont0", 0, 16'd102, 0);
    expect_res("cont1", 1, 16'd194, 0);

    // Requester 0 alone, then a tie must favour requester 1.
    run_burst(0, 16'd5, 8'd1, 1, '{16'd1, 16'd0, 16'd0, 16'd0}, '{0, 0, 0, 0}, -1, lt);
    wait_results("solo", 1);
    expect_res("solo", 0, 16'd6, 0);
    a0 = 16'd0; len0 = 8'd1; b0 = 16'd0; a1 = 16'd40; len1 = 8'd1; b1 = 16'd2;
    sub = 2'b00; bvalid = 2'b11; req = 2'b11;
    g = 0;
    do begin
      @(negedge Clock);
      g++;
    end while (grant == 2'b00 && g < 20);
    check("pref_grant", grant, 2'b10);
    @(posedge Clock); #1;
    req = 2'b00;
    wait_results("pref", 1);
    bvalid = 2'b00;
    expect_res("pref", 1, 16'd42, 0);

    // len0 = 0 acts as one beat, back-to-back with requester 1.
    @(posedge Clock); #1;
    a0 = 16'd1; len0 = 8'd0; b0 = 16'd5; a1 = 16'd50; len1 = 8'd1; b1 = 16'd7;
    sub = 2'b00; bvalid = 2'b11; req = 2'b11;
    serve_both("b2b", 2);
    expect_res("b2b0", 0, 16'd6, 0);
    c1 = popped_cyc;
    expect_res("b2b1", 1, 16'd57, 0);
    check("b2b_spacing", popped_cyc - c1, 2);

    // Reset during beat 2 of 4.
    @(posedge Clock); #1;
    a0 = 16'd0; len0 = 8'd4; b0 = 16'd1; sub = 2'b00; bvalid = 2'b01; req = 2'b01;
    g = 0; lt = 0;
    while (lt < 2 && g < 30) begin
      @(negedge Clock);
      g++;
      if (take[0]) lt++;
      if (lt < 2) begin
        @(posedge Clock); #1;
        if (grant[0]) req = 2'b00;
      end
    end
    check("mid_reached", lt, 2);
    Resetn = 1'b0;
    bvalid = 2'b00; req = 2'b00;
    #1;
    check("mid_grant", grant, 0);
    check("mid_take", take, 0);
    check("mid_res_valid", res_valid, 0);
    check("mid_busy", busy, 0);
    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b1;
    repeat (10) @(negedge Clock);
    check("mid_no_stale", rq.size(), 0);
    check("mid_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addsub_scheduler.md
Name: addsub_scheduler

Overview:
- Round-robin scheduler that shares one registered adder/subtractor datapath (n-bit, 2-cycle latency, Sel feedback mux) between two requesters.
- Each granted requester runs an accumulate burst: a start value A, then LEN signed B operands, each added or subtracted.
- Drives the datapath A/B/Sel/AddSub, tracks in-flight beats, and returns one final sum per burst with requester ID and sticky overflow.
- The top level instantiates it beside the datapath; the datapath reset is tied to ~Resetn.

Parameters:
- N, 16, operand/result width; must equal datapath n.
- LW, 8, burst-length field width.
- LAT, 2, datapath issue-to-Z latency in cycles; fixed, not user-tunable.

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous active-low reset
- req  in  2  level burst request per requester; sampled only in IDLE
- a0, a1  in  N  start value; captured on grant
- len0, len1  in  LW  number of B beats; captured on grant; 0 is treated as 1
- b0, b1  in  N  current B operand
- sub  in  2  per-beat op: 0 = add, 1 = subtract
- bvalid  in  2  current b/sub valid
- grant  out  2  one-hot owner; high for the whole RUN
- take  out  2  b/sub of the owner consumed this cycle (bvalid & RUN)
- dp_a, dp_b  out  N  to datapath A, B
- dp_sel, dp_addsub  out  1  to datapath Sel, AddSub
- dp_z  in  N  datapath Z
- dp_ovf  in  1  datapath Overflow
- res_valid  out  1  one-cycle pulse per completed burst
- res_id  out  1  requester of this result
- res_z  out  N  final accumulated value
- res_ovf  out  1  OR of overflow over all beats of the burst
- busy  out  1  state != IDLE or beats in flight

Behaviour:
- Reset: asynchronous, all outputs 0, state IDLE, round-robin pointer to requester 0, in-flight pipeline flushed. Reset mid-burst abandons the burst with no result.
- IDLE:
  - Drive dp_a=0, dp_b=0, dp_sel=0, dp_addsub=0.
  - If any req bit is set: grant the requester selected by the pointer (the pointer holder wins if both request), latch a/len, set first=1, go to RUN.
  - No issue happens in the grant cycle.
- RUN with bvalid[g]=1 (issue beat):
  - take[g]=1 and dp_b=b_g, dp_addsub=sub[g].
  - If first: dp_a=latched A, dp_sel=0, clear first. Otherwise dp_sel=1, so the datapath adds to the fed-back Z from the previous cycle's issue.
  - Decrement remaining beats.
  - On the last beat: go to IDLE, clear grant, and move the pointer to the other requester.
- RUN with bvalid[g]=0 (bubble):
  - If first: drive the IDLE values.
  - Otherwise issue a hold beat: dp_sel=1, dp_b=0, dp_addsub=0, so Z+0 preserves the partial sum.
  - Hold beats carry no beat tag.
- In-flight tracking: a 2-stage shift register of {valid, first, last, id}, loaded on each issue beat. Stage-2 output aligns with dp_z/dp_ovf in the same cycle.
- Accumulation at stage 2 when valid:
  - ovf_acc = first ? dp_ovf : ovf_acc | dp_ovf.
  - If last: register res_z=dp_z, res_ovf=that value, res_id=id, res_valid=1 next cycle.
- Latency: last beat issued in cycle c gives res_valid in cycle c+3. Consecutive bursts are separated by a 1-cycle grant gap; the pipeline overlaps so results never collide.
- A new burst's first beat uses Sel=0, so it is independent of the previous burst's Z.
- Arithmetic is N-bit two's complement wrap-around; overflow is only flagged, never saturated.
- req is ignored while in RUN. A requester may drop req after grant.
- There is no result backpressure; consumers must accept res_valid every cycle.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN}
  - LAT=2
  - in-flight tag struct {valid, first, last, id}
  - dp_sel encodings SEL_A=0, SEL_Z=1
- One sub-module, addsub_rr_arb: 2-way round-robin arbiter (req, advance pulse → one-hot grant, pointer).
- The burst FSM, beat counter, and tag pipeline stay in the top.

Test Plan:
- Single add burst: req0, a0=10, len0=3, b=5,7,-2 all add, bvalid continuous → res_z=20, res_ovf=0, res_id=0, res_valid 3 cycles after the last take.
- Subtract and overflow: a1=0x7FF0, len1=2, beats +0x20 add, then 0x30 subtract → res_z=0x7FE0, res_ovf=1 (sticky from beat 1).
- Bubbles: len0=3, b=1,2,3 with bvalid low for 2 cycles between beats 1 and 2 → hold beats issued (dp_sel=1, dp_b=0), res_z=a0+6.
- Contention: req=2'b11 from reset → requester 0 granted first, requester 1 second; results in order with correct ids; after req0 again, pointer favours requester 1.
- len=0 and back-to-back: len0=0 treated as 1 beat; immediately followed by a granted burst from requester 1; the first result is uncorrupted and both res_valid pulses are distinct.
- Reset mid-burst: Resetn low during beat 2 of 4 → grant, take, res_valid, and busy go to 0 immediately, with no stale result after release.
